// File: rtl/sync_fifo_pkg.sv
// Shared types for the single-clock programmable FIFO.
package sync_fifo_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

endpackage

// File: rtl/sync_fifo_prog_ram.sv
// Simple dual-port RAM: one write port, one registered read port that holds its
// output whenever no read is enabled.
module fifo_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // The read register doubles as the FWFT head word, so it must reset to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with standard or first-word-fall-through read mode, exact
// occupancy count, programmable almost flags, synchronous flush and sticky errors.
module sync_fifo_prog
    import sync_fifo_pkg::*;
#(
    parameter int         DATA_WIDTH = 32,
    parameter int         DEPTH      = 256,
    parameter int         ADDR_WIDTH = $clog2(DEPTH),
    parameter int         CNT_WIDTH  = ADDR_WIDTH + 1,
    parameter fifo_mode_e MODE       = FIFO_STD
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    output logic                  almost_full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  almost_empty,
    input  logic [CNT_WIDTH-1:0]  af_thresh,
    input  logic [CNT_WIDTH-1:0]  ae_thresh,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  err_clr
);

    localparam logic                 IS_FWFT = (MODE == FIFO_FWFT);
    localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(DEPTH);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [CNT_WIDTH-1:0]  mem_cnt;
    logic                  acc_wr;
    logic                  acc_rd;
    logic                  load;
    logic                  ram_wr;
    logic                  ram_rd;
    logic [DATA_WIDTH-1:0] ram_q;
    logic                  vld_p0;
    logic                  vld_p1;
    logic [DATA_WIDTH-1:0] data_p1;

    assign full         = (cnt_q == DEPTH_C);
    assign empty        = (cnt_q == '0);
    assign almost_full  = (af_thresh != '0) && (cnt_q >= af_thresh);
    assign almost_empty = (cnt_q <= ae_thresh);
    assign count        = cnt_q;
    assign rd_valid     = vld_p1;
    assign rd_data      = IS_FWFT ? ram_q : data_p1;

    // In FWFT the count includes the head word; mem_cnt is what still sits in RAM.
    always_comb begin
        acc_wr  = wr_en && !full;
        acc_rd  = IS_FWFT ? (rd_en && vld_p1) : (rd_en && !empty);
        mem_cnt = cnt_q - CNT_WIDTH'(vld_p1);
        load    = IS_FWFT && !flush && (mem_cnt != '0) && (!vld_p1 || acc_rd);
        ram_wr  = acc_wr && !flush;
        ram_rd  = IS_FWFT ? load : (acc_rd && !flush);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (ram_wr) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            if (ram_rd) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            case ({acc_wr, acc_rd})
                2'b10:   cnt_q <= cnt_q + CNT_WIDTH'(1);
                2'b01:   cnt_q <= cnt_q - CNT_WIDTH'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    fifo_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (ram_wr),
        .wr_addr(wr_ptr),
        .wr_data(wr_data),
        .rd_en  (ram_rd),
        .rd_addr(rd_ptr),
        .rd_data(ram_q)
    );

    // Output stage: STD adds one register after the RAM read (p0 -> p1);
    // FWFT uses the RAM read register itself as the head word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
            data_p1 <= '0;
        end else if (flush) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else if (IS_FWFT) begin
            vld_p0 <= 1'b0;
            if (load) begin
                vld_p1 <= 1'b1;
            end else if (acc_rd) begin
                vld_p1 <= 1'b0;
            end
        end else begin
            vld_p0 <= acc_rd;
            vld_p1 <= vld_p0;
            if (vld_p0) data_p1 <= ram_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && full)   overflow <= 1'b1;
            else if (err_clr)    overflow <= 1'b0;
            if (rd_en && empty)  underflow <= 1'b1;
            else if (err_clr)    underflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Bench for sync_fifo_prog: STD and FWFT instances share stimulus and are each
// compared every cycle against a queue-based model, plus literal spot checks.
module tb_sync_fifo_prog;
    import sync_fifo_pkg::*;

    localparam int DW = 8;
    localparam int D  = 16;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic          err_clr = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic [CW-1:0] af_thresh = 5'd12;
    logic [CW-1:0] ae_thresh = 5'd3;

    logic          s_full, s_af, s_rdv, s_empty, s_ae, s_ovf, s_udf;
    logic [DW-1:0] s_rdd;
    logic [CW-1:0] s_cnt;
    logic          f_full, f_af, f_rdv, f_empty, f_ae, f_ovf, f_udf;
    logic [DW-1:0] f_rdd;
    logic [CW-1:0] f_cnt;

    int   errors = 0;
    int   checks = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    sync_fifo_prog #(.DATA_WIDTH(DW), .DEPTH(D), .MODE(FIFO_STD)) u_std (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .full(s_full), .almost_full(s_af), .rd_en(rd_en), .rd_data(s_rdd),
        .rd_valid(s_rdv), .empty(s_empty), .almost_empty(s_ae),
        .af_thresh(af_thresh), .ae_thresh(ae_thresh), .count(s_cnt),
        .overflow(s_ovf), .underflow(s_udf), .err_clr(err_clr)
    );

    sync_fifo_prog #(.DATA_WIDTH(DW), .DEPTH(D), .MODE(FIFO_FWFT)) u_fwft (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .full(f_full), .almost_full(f_af), .rd_en(rd_en), .rd_data(f_rdd),
        .rd_valid(f_rdv), .empty(f_empty), .almost_empty(f_ae),
        .af_thresh(af_thresh), .ae_thresh(ae_thresh), .count(f_cnt),
        .overflow(f_ovf), .underflow(f_udf), .err_clr(err_clr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue per mode holds every word the FIFO owns.
    logic [DW-1:0] q_s[$];
    logic [DW-1:0] q_f[$];
    logic          sp_v, s_v, f_v;
    logic [DW-1:0] sp_d, s_d, f_d;
    logic          ovf_s, udf_s, ovf_f, udf_f;
    int            n, avail;
    logic          aw, ar;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q_s.delete(); q_f.delete();
            sp_v = 0; s_v = 0; f_v = 0;
            sp_d = '0; s_d = '0; f_d = '0;
            ovf_s = 0; udf_s = 0; ovf_f = 0; udf_f = 0;
        end else begin
            n = q_s.size();
            if (wr_en && n == D) ovf_s = 1; else if (err_clr) ovf_s = 0;
            if (rd_en && n == 0) udf_s = 1; else if (err_clr) udf_s = 0;
            if (flush) begin
                q_s.delete(); sp_v = 0; s_v = 0;
            end else begin
                aw = wr_en && (n < D);
                ar = rd_en && (n > 0);
                s_v = sp_v;
                if (sp_v) s_d = sp_d;
                sp_v = ar;
                if (ar) sp_d = q_s.pop_front();
                if (aw) q_s.push_back(wr_data);
            end

            n = q_f.size();
            if (wr_en && n == D) ovf_f = 1; else if (err_clr) ovf_f = 0;
            if (rd_en && n == 0) udf_f = 1; else if (err_clr) udf_f = 0;
            if (flush) begin
                q_f.delete(); f_v = 0;
            end else begin
                aw = wr_en && (n < D);
                ar = rd_en && f_v;
                avail = n - (f_v ? 1 : 0);
                if (ar) void'(q_f.pop_front());
                if (!f_v || ar) begin
                    f_v = (avail > 0);
                    if (avail > 0) f_d = q_f[0];
                end
                if (aw) q_f.push_back(wr_data);
            end
        end
    end

    function automatic logic exp_af(input int cnt);
        return (af_thresh != 0) && (cnt >= int'(af_thresh));
    endfunction

    function automatic logic exp_ae(input int cnt);
        return cnt <= int'(ae_thresh);
    endfunction

    int ns, nf;
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            ns = q_s.size();
            nf = q_f.size();
            chk("std_count", s_cnt, ns);
            chk("std_full", s_full, ns == D);
            chk("std_empty", s_empty, ns == 0);
            chk("std_af", s_af, exp_af(ns));
            chk("std_ae", s_ae, exp_ae(ns));
            chk("std_rd_valid", s_rdv, s_v);
            chk("std_rd_data", s_rdd, s_d);
            chk("std_overflow", s_ovf, ovf_s);
            chk("std_underflow", s_udf, udf_s);
            chk("fwft_count", f_cnt, nf);
            chk("fwft_full", f_full, nf == D);
            chk("fwft_empty", f_empty, nf == 0);
            chk("fwft_af", f_af, exp_af(nf));
            chk("fwft_ae", f_ae, exp_ae(nf));
            chk("fwft_rd_valid", f_rdv, f_v);
            chk("fwft_rd_data", f_rdd, f_d);
            chk("fwft_overflow", f_ovf, ovf_f);
            chk("fwft_underflow", f_udf, udf_f);
        end
    end

    task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r);
        wr_en = w; wr_data = d; rd_en = r;
        @(posedge clk); #1;
    endtask

    task automatic clear_errs();
        err_clr = 1'b1;
        cyc(1'b0, '0, 1'b0);
        err_clr = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        cyc(1'b0, '0, 1'b0);
        flush = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    int nxt;
    int acks;
    int wp, rp;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;
        chk("rst_count_std", s_cnt, 0);
        chk("rst_empty_std", s_empty, 1);
        chk("rst_ae_std", s_ae, 1);
        chk("rst_af_fwft", f_af, 0);
        chk("rst_full_fwft", f_full, 0);
        chk("rst_rd_valid_fwft", f_rdv, 0);

        // fill to full, then one overflowing write
        for (int i = 0; i < 16; i++) cyc(1'b1, DW'(i), 1'b0);
        chk("fill_count_std", s_cnt, 16);
        chk("fill_count_fwft", f_cnt, 16);
        chk("fill_full_std", s_full, 1);
        chk("fill_full_fwft", f_full, 1);
        cyc(1'b1, 8'hEE, 1'b0);
        chk("ovf_std", s_ovf, 1);
        chk("ovf_fwft", f_ovf, 1);
        chk("ovf_count_std", s_cnt, 16);

        // drain in order, one extra read underflows
        nxt = 0;
        for (int i = 0; i < 19; i++) begin
            cyc(1'b0, '0, i < 17);
            if (s_rdv) begin
                chk("drain_order_std", s_rdd, nxt);
                nxt++;
            end
        end
        chk("drain_words_std", nxt, 16);
        chk("drain_empty_fwft", f_empty, 1);
        chk("udf_std", s_udf, 1);
        chk("udf_fwft", f_udf, 1);
        clear_errs();
        chk("errclr_ovf_std", s_ovf, 0);
        chk("errclr_udf_fwft", f_udf, 0);

        // simultaneous read/write at 8 and at full
        for (int i = 0; i < 8; i++) cyc(1'b1, DW'($urandom), 1'b0);
        for (int i = 0; i < 20; i++) cyc(1'b1, DW'($urandom), 1'b1);
        chk("rw8_count_std", s_cnt, 8);
        chk("rw8_count_fwft", f_cnt, 8);
        for (int i = 0; i < 8; i++) cyc(1'b1, DW'($urandom), 1'b0);
        cyc(1'b1, 8'h11, 1'b1);
        chk("rw16_count_std", s_cnt, 15);
        chk("rw16_count_fwft", f_cnt, 15);
        do_flush();
        cyc(1'b1, 8'h3C, 1'b1);
        chk("rw0_count_std", s_cnt, 1);
        chk("rw0_count_fwft", f_cnt, 1);
        chk("rw0_udf_std", s_udf, 1);
        clear_errs();

        // FWFT latency and sustained streaming
        do_flush();
        cyc(1'b1, 8'hA5, 1'b0);
        chk("fwft_lat_empty", f_empty, 0);
        chk("fwft_lat_valid0", f_rdv, 0);
        cyc(1'b0, '0, 1'b0);
        chk("fwft_lat_valid1", f_rdv, 1);
        chk("fwft_lat_data", f_rdd, 8'hA5);
        cyc(1'b1, DW'($urandom), 1'b0);
        acks = 0;
        for (int i = 0; i < 40; i++) begin
            if (f_rdv) acks++;
            cyc(1'b1, DW'($urandom), 1'b1);
        end
        chk("fwft_stream_acks", acks, 40);

        // flush at count 9 with concurrent traffic, overflow held
        do_flush();
        for (int i = 0; i < 17; i++) cyc(1'b1, DW'($urandom), 1'b0);
        for (int i = 0; i < 7; i++) cyc(1'b0, '0, 1'b1);
        chk("pre_flush_count_std", s_cnt, 9);
        chk("pre_flush_count_fwft", f_cnt, 9);
        flush = 1'b1;
        cyc(1'b1, 8'h77, 1'b1);
        flush = 1'b0;
        chk("flush_count_std", s_cnt, 0);
        chk("flush_count_fwft", f_cnt, 0);
        chk("flush_empty_fwft", f_empty, 1);
        chk("flush_rdv_std", s_rdv, 0);
        chk("flush_rdv_fwft", f_rdv, 0);
        chk("flush_ovf_std", s_ovf, 1);
        chk("flush_ovf_fwft", f_ovf, 1);
        clear_errs();

        // randomized traffic with phase-biased fill/drain
        for (int i = 0; i < 900; i++) begin
            case ((i / 100) % 3)
                0:       begin wp = 80; rp = 25; end
                1:       begin wp = 25; rp = 80; end
                default: begin wp = 50; rp = 50; end
            endcase
            wr_en   = ($urandom_range(0, 99) < wp);
            rd_en   = ($urandom_range(0, 99) < rp);
            wr_data = DW'($urandom);
            flush   = ($urandom_range(0, 99) < 2);
            err_clr = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 99) < 3) begin
                af_thresh = CW'($urandom);
                ae_thresh = CW'($urandom);
            end
            @(posedge clk); #1;
        end
        flush = 1'b0; err_clr = 1'b0;
        af_thresh = 5'd12; ae_thresh = 5'd3;

        // asynchronous reset in the middle of a stream
        for (int i = 0; i < 18; i++) cyc(1'b1, DW'($urandom), 1'b0);
        wr_en = 1'b1; rd_en = 1'b1;
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("mid_rst_count_std", s_cnt, 0);
        chk("mid_rst_count_fwft", f_cnt, 0);
        chk("mid_rst_empty_std", s_empty, 1);
        chk("mid_rst_full_fwft", f_full, 0);
        chk("mid_rst_rdv_std", s_rdv, 0);
        chk("mid_rst_rdv_fwft", f_rdv, 0);
        chk("mid_rst_rdd_fwft", f_rdd, 0);
        chk("mid_rst_ovf_std", s_ovf, 0);
        chk("mid_rst_ovf_fwft", f_ovf, 0);
        chk("mid_rst_ae_fwft", f_ae, 1);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 60; i++) cyc($urandom_range(0, 1), DW'($urandom), $urandom_range(0, 1));
        cyc(1'b0, '0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
